button_debounce_sync: RTL and testbench

Parametrised multi-channel front end for mechanical push-buttons. Each channel passes a raw asynchronous pin through a configurable synchroniser chain, then through a counter-based debounce filter. Each channel outputs a clean level, one-cycle press and release pulses, and optionally a toggle state. The block sits between the board button pins and user logic, in place of ad-hoc flop chains, and drives LEDs or control logic directly.

---
 rtl/button_debounce_sync_pkg.sv | 24 ++
 rtl/button_debounce_sync_channel.sv | 162 ++++++++++++++++
 rtl/button_debounce_sync.sv | 49 ++++
 tb/tb_button_debounce_sync.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_sync_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_sync_pkg
// Shared definitions for the button debounce front end:
//   - deb_state_t : per-channel debounce FSM state encoding
//   - cnt_width() : width of the per-channel stability counter
// Optional feature macro used by the design: BUTTON_DEBOUNCE_TOGGLE_EN
// -----------------------------------------------------------------------------
package button_debounce_sync_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESSING  = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } deb_state_t;

    // Counter must hold values 0..cycles, so $clog2(cycles+1) bits (at least 1).
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_debounce_sync_channel.sv
// -----------------------------------------------------------------------------
// button_debounce_channel
// One button channel: synchroniser chain, debounce FSM with stability counter,
// registered level / press / release outputs and optional toggle flop.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   but_i      raw asynchronous button pin
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse when level_o rises
//   release_o  one-cycle pulse when level_o falls
//   toggle_o   flips on each press (only with BUTTON_DEBOUNCE_TOGGLE_EN,
//              otherwise tied to 0)
// -----------------------------------------------------------------------------
module button_debounce_channel
    import button_debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic but_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic toggle_o
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic             PIN_IDLE = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam bit               NO_COUNT = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   cnt_done;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    // The chain resets to the released pin level so that s reads "not pressed"
    // straight out of reset; a held button is then debounced from scratch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{PIN_IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], but_i};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1] ^ PIN_IDLE;
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign cnt_done = (cnt_inc == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    if (NO_COUNT) begin
                        state_d = ST_PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        state_d = ST_PRESSING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_PRESSING: begin
                if (!s) begin
                    // bounce: abandon the attempt silently
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    if (NO_COUNT) begin
                        state_d   = ST_RELEASED;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_RELEASING: begin
                if (s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            toggle_q <= 1'b0;
        end else if (press_d) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign toggle_o = toggle_q;
`else
    assign toggle_o = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_sync.sv
// -----------------------------------------------------------------------------
// button_debounce_sync
// Multi-channel push-button front end: CHANNELS independent copies of
// button_debounce_channel.
//
// Ports:
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   BUT      raw asynchronous button pins [CHANNELS]
//   LEVEL    debounced level per channel, 1 = pressed
//   PRESS    one-cycle pulse per channel on LEVEL 0->1
//   RELEASE  one-cycle pulse per channel on LEVEL 1->0
//   TOGGLE   per-channel toggle state, flips on PRESS; tied to 0 unless
//            BUTTON_DEBOUNCE_TOGGLE_EN is defined
// -----------------------------------------------------------------------------
module button_debounce_sync
    import button_debounce_sync_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] BUT,
    output logic [CHANNELS-1:0] LEVEL,
    output logic [CHANNELS-1:0] PRESS,
    output logic [CHANNELS-1:0] RELEASE,
    output logic [CHANNELS-1:0] TOGGLE
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        button_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk_i     (CLK),
            .rst_i     (RST),
            .but_i     (BUT[gi]),
            .level_o   (LEVEL[gi]),
            .press_o   (PRESS[gi]),
            .release_o (RELEASE[gi]),
            .toggle_o  (TOGGLE[gi])
        );
    end

endmodule

// File: tb/tb_button_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_sync
// Scoreboard bench: stimulus pushes the expected press/release events
// (channel, kind, cycle, level, toggle) into a queue; a monitor pops and
// compares whenever the DUT raises PRESS or RELEASE.
// -----------------------------------------------------------------------------
module tb_button_debounce_sync;

    localparam int CH  = 2;
    localparam int LAT = 3 + 4;   // SYNC_STAGES + DEBOUNCE_CYCLES

    logic          CLK = 1'b0;
    logic          RST;
    logic [CH-1:0] BUT;
    logic [CH-1:0] LEVEL, PRESS, RELEASE, TOGGLE;

    typedef struct {
        int ch;
        bit is_press;
        int cyc;
        bit lvl;
        bit tog;
    } exp_t;

    exp_t    q[$];
    int      cyc    = 0;
    int      checks = 0;
    int      errors = 0;
    bit [CH-1:0] tog_exp = '0;

    button_debounce_sync #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BUT     (BUT),
        .LEVEL   (LEVEL),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .TOGGLE  (TOGGLE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Expected event LAT edges after the pin change made now.
    task automatic push(input int ch, input bit is_press);
        exp_t e;
        if (is_press) begin
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
            tog_exp[ch] = ~tog_exp[ch];
`endif
        end
        e.ch       = ch;
        e.is_press = is_press;
        e.cyc      = cyc + LAT;
        e.lvl      = is_press;
        e.tog      = tog_exp[ch];
        q.push_back(e);
    endtask

    task automatic check_vec(input string name, input logic [CH-1:0] got, input logic [CH-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b at cycle %0d", name, got, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_level"},   LEVEL,   '0);
        check_vec({tag, "_press"},   PRESS,   '0);
        check_vec({tag, "_release"}, RELEASE, '0);
        check_vec({tag, "_toggle"},  TOGGLE,  '0);
    endtask

    // Monitor
    always @(negedge CLK) begin
        exp_t e;
        for (int ch = 0; ch < CH; ch++) begin
            if (PRESS[ch] || RELEASE[ch]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: ch%0d press=%0b release=%0b at cycle %0d, required no event",
                             ch, PRESS[ch], RELEASE[ch], cyc);
                end else begin
                    e = q.pop_front();
                    if (e.ch != ch || PRESS[ch] !== e.is_press || RELEASE[ch] !== !e.is_press ||
                        cyc != e.cyc || LEVEL[ch] !== e.lvl || TOGGLE[ch] !== e.tog) begin
                        errors++;
                        $display("FAIL event: got ch%0d press=%0b release=%0b cycle=%0d level=%0b toggle=%0b; required ch%0d press=%0b release=%0b cycle=%0d level=%0b toggle=%0b",
                                 ch, PRESS[ch], RELEASE[ch], cyc, LEVEL[ch], TOGGLE[ch],
                                 e.ch, e.is_press, !e.is_press, e.cyc, e.lvl, e.tog);
                    end else begin
                        $display("event ok: ch%0d %s at cycle %0d level=%0b toggle=%0b",
                                 ch, e.is_press ? "press" : "release", cyc, LEVEL[ch], TOGGLE[ch]);
                    end
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        BUT = 2'b11;
        tick(3);
        check_reset_outputs("reset");
        RST = 1'b0;
        tick(10);
        check_vec("idle_level", LEVEL, 2'b00);

        // Clean press on ch0
        BUT[0] = 1'b0;
        push(0, 1'b1);
        tick(12);
        check_vec("press_level", LEVEL, 2'b01);

        // Release ch0
        BUT[0] = 1'b1;
        push(0, 1'b0);
        tick(12);
        check_vec("release_level", LEVEL, 2'b00);

        // Glitch: 3 low cycles must be rejected
        BUT[0] = 1'b0;
        tick(3);
        BUT[0] = 1'b1;
        tick(12);
        check_vec("glitch_level", LEVEL, 2'b00);

        // Bounce: low 2, high 1, then low held
        BUT[0] = 1'b0;
        tick(2);
        BUT[0] = 1'b1;
        tick(1);
        BUT[0] = 1'b0;
        push(0, 1'b1);
        tick(12);
        check_vec("bounce_level", LEVEL, 2'b01);
        BUT[0] = 1'b1;
        push(0, 1'b0);
        tick(12);

        // Both channels pressed and released together
        BUT = 2'b00;
        push(0, 1'b1);
        push(1, 1'b1);
        tick(12);
        check_vec("both_level", LEVEL, 2'b11);
        BUT = 2'b11;
        push(0, 1'b0);
        push(1, 1'b0);
        tick(12);

        // Reset in the middle of a press count
        BUT[0] = 1'b0;
        tick(5);
        RST = 1'b1;
        tog_exp = '0;
        tick(1);
        check_reset_outputs("rst_mid1");
        tick(1);
        check_reset_outputs("rst_mid2");
        RST = 1'b0;
        push(0, 1'b1);
        tick(12);
        check_vec("rst_press_level", LEVEL, 2'b01);
        BUT[0] = 1'b1;
        push(0, 1'b0);
        tick(12);

        // Three presses on ch1 for the toggle
        for (int i = 0; i < 3; i++) begin
            BUT[1] = 1'b0;
            push(1, 1'b1);
            tick(12);
            BUT[1] = 1'b1;
            push(1, 1'b0);
            tick(12);
        end
        check_vec("final_toggle", TOGGLE, tog_exp);

        tick(5);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none, required ch%0d %s at cycle %0d",
                     e.ch, e.is_press ? "press" : "release", e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
